// File: rtl/udc_sched.sv
// Two-requester up/down counter burst scheduler with round-robin arbitration.
// Optional build macro UDC_SAT_EN: counter saturates at 0 / 2^CW-1 instead of wrapping.
module udc_sched #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          ud0,
    input  logic          ud1,
    input  logic [3:0]    len0,
    input  logic [3:0]    len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          busy,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            owner_reg;
    logic            prio_reg;      // requester favoured on a tie
    logic            dir_q;
    logic [3:0]      rem_q;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            pick;
    logic [3:0]      len_sel;
    logic            ud_sel;
    logic [1:0]      gnt_vec;
    logic [1:0]      done_vec;

    // Arbitration: a lone requester wins; on a tie the favoured one wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = prio_reg;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    assign len_sel = owner_reg ? len1 : len0;
    assign ud_sel  = owner_reg ? ud1  : ud0;

    always_comb begin
        count_next = count_reg;
        if (dir_q) begin
`ifdef UDC_SAT_EN
            if (count_reg != {CW{1'b1}}) begin
                count_next = count_reg + 1'b1;
            end
`else
            count_next = count_reg + 1'b1;
`endif
        end else begin
`ifdef UDC_SAT_EN
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end
`else
            count_next = count_reg - 1'b1;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = (len_sel != 4'd0) ? RUN : DONE;
            end
            RUN: begin
                // rem_q hits zero on this step
                if (rem_q == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            prio_reg  <= 1'b0;
            dir_q     <= 1'b0;
            rem_q     <= 4'd0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_reg <= pick;
                    end
                end
                GRANT: begin
                    dir_q    <= ud_sel;
                    rem_q    <= len_sel;
                    prio_reg <= ~owner_reg;
                end
                RUN: begin
                    count_reg <= count_next;
                    rem_q     <= rem_q - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req_out
            assign gnt_vec[gi]  = (state_reg == GRANT) && (owner_reg == 1'(gi));
            assign done_vec[gi] = (state_reg == DONE)  && (owner_reg == 1'(gi));
        end
    endgenerate

    assign gnt0  = gnt_vec[0];
    assign gnt1  = gnt_vec[1];
    assign done0 = done_vec[0];
    assign done1 = done_vec[1];
    assign busy  = (state_reg != IDLE);
    assign count = count_reg;

endmodule
